// File: rtl/regfile_sb.sv
// regfile_sb: parametrised multi-read-port register file with a pending-write
// scoreboard, write-to-read bypass and a one-register-per-cycle clear engine
// that runs after every reset.
//
// Handshake note: this block has no valid/ready pairs. wr_en_i and iss_en_i
// are single-cycle strobes that are accepted on the rising edge only while
// busy_o is 0. While busy_o is 1 they are silently dropped. Callers must hold
// off until busy_o falls.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  output logic [NUM_RD-1:0]        rd_pend_o,
  input  logic                     wr_en_i,
  input  logic [ADDR_W-1:0]        wr_addr_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  input  logic                     iss_en_i,
  input  logic [ADDR_W-1:0]        iss_addr_i,
  output logic                     busy_o,
  output logic                     pend_any_o
);

  typedef enum logic {ST_CLEAR, ST_READY} state_e;

  localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);

  state_e              state_q;
  logic [ADDR_W-1:0]   clr_ptr_q;
  logic [NUM_REGS-1:0] pend_q;
  logic [DATA_W-1:0]   mem_q [NUM_REGS];

  logic ready;
  logic wr_ok;
  logic iss_ok;

  // An address names a real, writable register: in range and not the
  // hard-wired zero register.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    logic in_range;
    logic is_zero;
    in_range = int'(a) < NUM_REGS;
    is_zero  = (ZERO_REG != 0) && (a == '0);
    return in_range && !is_zero;
  endfunction

  assign ready  = (state_q == ST_READY);
  assign wr_ok  = wr_en_i  && !rst_i && ready && addr_ok(wr_addr_i);
  assign iss_ok = iss_en_i && !rst_i && ready && addr_ok(iss_addr_i);

  // Control FSM: clear sequencing plus the pending-bit scoreboard.
  // Issue is applied after writeback so a same-address issue leaves pend set.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_CLEAR;
      clr_ptr_q <= '0;
      pend_q    <= '0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          if (clr_ptr_q == LAST_REG) begin
            state_q <= ST_READY;
          end else begin
            clr_ptr_q <= clr_ptr_q + ADDR_W'(1);
          end
        end
        default: begin
          if (wr_ok) begin
            pend_q[wr_addr_i] <= 1'b0;
          end
          if (iss_ok) begin
            pend_q[iss_addr_i] <= 1'b1;
          end
        end
      endcase
    end
  end

  // Storage array: zeroed one entry per cycle during clear, else writeback.
  // Reset itself leaves the contents alone; the clear engine does the work.
  always_ff @(posedge clk_i) begin
    if (!rst_i && state_q == ST_CLEAR) begin
      mem_q[clr_ptr_q] <= '0;
    end else if (wr_ok) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Read ports: out-of-range and zero-register reads give 0, a matching
  // valid write is forwarded when bypass is enabled, else the stored value.
  always_comb begin
    rd_data_o = '0;
    rd_pend_o = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      logic [ADDR_W-1:0] ra;
      ra = rd_addr_i[k*ADDR_W +: ADDR_W];
      if (ready && addr_ok(ra)) begin
        if ((BYPASS != 0) && wr_ok && (wr_addr_i == ra)) begin
          rd_data_o[k*DATA_W +: DATA_W] = wr_data_i;
          rd_pend_o[k]                  = 1'b0;
        end else begin
          rd_data_o[k*DATA_W +: DATA_W] = mem_q[ra];
          rd_pend_o[k]                  = pend_q[ra];
        end
      end
    end
  end

  assign busy_o     = (state_q == ST_CLEAR);
  assign pend_any_o = ready && (|pend_q);

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed test of regfile_sb in three configurations
// (defaults, no bypass, 20 registers with 3 read ports) sharing one stimulus.
module tb_regfile_sb;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic [9:0]  rd_addr;
  logic [4:0]  rd2;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        iss_en;
  logic [4:0]  iss_addr;

  logic [63:0] rd_data_a, rd_data_b;
  logic [95:0] rd_data_c;
  logic [1:0]  rd_pend_a, rd_pend_b;
  logic [2:0]  rd_pend_c;
  logic        busy_a, busy_b, busy_c;
  logic        pend_any_a, pend_any_b, pend_any_c;

  int total = 0;
  int bad   = 0;
  int na, nc;

  regfile_sb u_a (
    .clk_i(clk), .rst_i(rst), .rd_addr_i(rd_addr), .rd_data_o(rd_data_a),
    .rd_pend_o(rd_pend_a), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .iss_en_i(iss_en), .iss_addr_i(iss_addr),
    .busy_o(busy_a), .pend_any_o(pend_any_a)
  );

  regfile_sb #(.BYPASS(0)) u_b (
    .clk_i(clk), .rst_i(rst), .rd_addr_i(rd_addr), .rd_data_o(rd_data_b),
    .rd_pend_o(rd_pend_b), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .iss_en_i(iss_en), .iss_addr_i(iss_addr),
    .busy_o(busy_b), .pend_any_o(pend_any_b)
  );

  regfile_sb #(.NUM_REGS(20), .NUM_RD(3)) u_c (
    .clk_i(clk), .rst_i(rst), .rd_addr_i({rd2, rd_addr}), .rd_data_o(rd_data_c),
    .rd_pend_o(rd_pend_c), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .iss_en_i(iss_en), .iss_addr_i(iss_addr),
    .busy_o(busy_c), .pend_any_o(pend_any_c)
  );

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
  endtask

  // Counts edges until each clear finishes (bounded at 40 edges).
  // Strobes are dropped as soon as u_a leaves busy.
  task automatic count_clear();
    na = 0;
    nc = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (!busy_a && na == 0) begin
        na     = i;
        wr_en  = 1'b0;
        iss_en = 1'b0;
      end
      if (!busy_c && nc == 0) nc = i;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; rd_addr = '0; rd2 = '0; wr_en = 1'b0; wr_addr = '0;
    wr_data = '0; iss_en = 1'b0; iss_addr = '0;

    // Reset state
    repeat (3) tick();
    check("rst_busy_a", 64'(busy_a), 64'd1);
    check("rst_busy_c", 64'(busy_c), 64'd1);
    check("rst_data_a", rd_data_a, 64'd0);
    check("rst_pend_a", 64'(rd_pend_a), 64'd0);
    check("rst_pany_a", 64'(pend_any_a), 64'd0);

    // Clear length
    rst = 1'b0;
    count_clear();
    check("clear_len_32", 64'(na), 64'd32);
    check("clear_len_20", 64'(nc), 64'd20);
    check("ready_busy_b", 64'(busy_b), 64'd0);

    // All registers read zero after clear
    for (int k = 0; k < 32; k++) begin
      set_rd(5'(k), 5'(31 - k));
      #1;
      check("clear_read", rd_data_a, 64'd0);
    end
    check("clear_pany", 64'(pend_any_a), 64'd0);

    // Bypass vs. no bypass
    set_rd(5, 5);
    wr_en = 1'b1; wr_addr = 5; wr_data = 32'hDEADBEEF;
    #1;
    check("byp_same_cyc_a", rd_data_a, 64'hDEADBEEF_DEADBEEF);
    check("nobyp_same_cyc_b", rd_data_b, 64'd0);
    tick();
    wr_en = 1'b0;
    #1;
    check("byp_after_a", rd_data_a, 64'hDEADBEEF_DEADBEEF);
    check("nobyp_after_b", rd_data_b, 64'hDEADBEEF_DEADBEEF);

    // Register 0 is hard-wired
    set_rd(0, 0);
    wr_en = 1'b1; wr_addr = 0; wr_data = 32'h12345678;
    iss_en = 1'b1; iss_addr = 0;
    #1;
    check("x0_data_wcyc", rd_data_a, 64'd0);
    check("x0_pend_wcyc", 64'(rd_pend_a), 64'd0);
    tick();
    wr_en = 1'b0; iss_en = 1'b0;
    #1;
    check("x0_data", rd_data_a, 64'd0);
    check("x0_pend", 64'(rd_pend_a), 64'd0);
    check("x0_pany", 64'(pend_any_a), 64'd0);

    // Scoreboard on x7
    set_rd(7, 7);
    iss_en = 1'b1; iss_addr = 7;
    #1;
    check("iss_same_cyc_pend", 64'(rd_pend_a), 64'd0);
    tick();
    iss_en = 1'b0;
    #1;
    check("iss_pend_a", 64'(rd_pend_a), 64'd3);
    check("iss_pany_a", 64'(pend_any_a), 64'd1);
    check("iss_pend_b", 64'(rd_pend_b), 64'd3);
    wr_en = 1'b1; wr_addr = 7; wr_data = 32'hA5;
    #1;
    check("wb_pend_byp_a", 64'(rd_pend_a), 64'd0);
    check("wb_data_byp_a", rd_data_a, 64'h000000A5_000000A5);
    check("wb_pend_nobyp_b", 64'(rd_pend_b), 64'd3);
    check("wb_data_nobyp_b", rd_data_b, 64'd0);
    tick();
    wr_en = 1'b0;
    #1;
    check("wb_pany_a", 64'(pend_any_a), 64'd0);
    check("wb_pany_b", 64'(pend_any_b), 64'd0);
    check("wb_data_a", rd_data_a, 64'h000000A5_000000A5);
    wr_en = 1'b1; wr_addr = 7; wr_data = 32'h3C;
    iss_en = 1'b1; iss_addr = 7;
    tick();
    wr_en = 1'b0; iss_en = 1'b0;
    #1;
    check("iss_wins_data", rd_data_a, 64'h0000003C_0000003C);
    check("iss_wins_pend", 64'(rd_pend_a), 64'd3);
    check("iss_wins_pany", 64'(pend_any_a), 64'd1);

    // Out-of-range on the 20-register instance
    set_rd(5, 7);
    rd2 = 25;
    wr_en = 1'b1; wr_addr = 25; wr_data = 32'hCAFEF00D;
    #1;
    check("oor_read_wcyc_c", 64'(rd_data_c[95:64]), 64'd0);
    tick();
    wr_en = 1'b0;
    #1;
    check("oor_read_c", 64'(rd_data_c[95:64]), 64'd0);
    check("oor_pend_c", 64'(rd_pend_c), 64'd2);
    check("c_x5_c", 64'(rd_data_c[31:0]), 64'hDEADBEEF);
    check("c_x7_c", 64'(rd_data_c[63:32]), 64'h3C);

    // Reset in the middle of clear
    set_rd(3, 3);
    wr_en = 1'b1; wr_addr = 3; wr_data = 32'h55;
    tick();
    wr_en = 1'b0;
    #1;
    check("x3_written", rd_data_a, 64'h00000055_00000055);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rerst_busy", 64'(busy_a), 64'd1);
    check("rerst_data", rd_data_a, 64'd0);
    check("rerst_pany", 64'(pend_any_a), 64'd0);
    wr_en = 1'b1; wr_addr = 3; wr_data = 32'h99;
    iss_en = 1'b1; iss_addr = 4;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    count_clear();
    check("restart_len_32", 64'(na), 64'd32);
    check("restart_len_20", 64'(nc), 64'd20);
    #1;
    check("x3_cleared_a", rd_data_a, 64'd0);
    check("x3_cleared_b", rd_data_b, 64'd0);
    check("busy_write_pany", 64'(pend_any_a), 64'd0);

    // ---------------- final report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
